unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the core's instruction-fetch and load/store requesters.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_grant.sv | 30 +++
 rtl/unified_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, transaction owner encoding, bus widths and the
// latched request record carried from accept to memory issue.
package mem_arb_pkg;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t          owner;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [SW-1:0]   wstrb;
  } req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between instruction fetch and load/store requesters.
// Latency: purely combinational, grant follows valids in the same cycle.
// Backpressure: no grant at all unless the arbiter FSM is idle.
// Ports: i_if_valid / i_d_valid  - requester valids
//        i_idle                  - FSM can accept a new transaction
//        i_starve_hit            - fetch has waited long enough, override data priority
//        o_grant_if / o_grant_d  - one-hot or zero grant
module mem_arb_grant (
  input  logic i_if_valid,
  input  logic i_d_valid,
  input  logic i_idle,
  input  logic i_starve_hit,
  output logic o_grant_if,
  output logic o_grant_d
);

  always_comb begin
    o_grant_if = 1'b0;
    o_grant_d  = 1'b0;
    if (i_idle) begin
      // Data normally wins; the starve override only matters when fetch is also waiting.
      if (i_d_valid && !(i_starve_hit && i_if_valid)) begin
        o_grant_d = 1'b1;
      end else if (i_if_valid) begin
        o_grant_if = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Latency: accept at T, mem_en at T+1, response pulse at T+MEM_LAT+2, next accept >= T+MEM_LAT+3.
// Backpressure: one outstanding transaction; both readies low outside IDLE, requests stay pending.
// Ports: clk/rst (sync, active-high); if_req_*/if_rsp_* fetch side; d_req_*/d_rsp_* load/store side;
//        mem_* towards the memory macro (mem_rdata valid MEM_LAT cycles after mem_en); busy = not IDLE.
// Build option: define ARB_STARVE_GUARD_EN to let fetch win after STARVE_MAX consecutive data grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [SW-1:0] d_wstrb,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_wstrb,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  req_t             r_req;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_rsp_data;

  logic w_idle;
  logic w_grant_if;
  logic w_grant_d;
  logic w_starve_hit;
  logic w_last_wait;

  assign w_idle      = (r_state == IDLE);
  assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_W'(1));

  mem_arb_grant u_grant (
    .i_if_valid   (if_req_valid),
    .i_d_valid    (d_req_valid),
    .i_idle       (w_idle),
    .i_starve_hit (w_starve_hit),
    .o_grant_if   (w_grant_if),
    .o_grant_d    (w_grant_d)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_starve;

  // Counts data grants that overtook a waiting fetch; any fetch grant resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant_if) begin
      r_starve <= '0;
    end else if (w_grant_d && if_req_valid) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  assign w_starve_hit = (r_starve == CNT_W'(STARVE_MAX));
`else
  logic w_unused_starve_cfg;
  assign w_unused_starve_cfg = (STARVE_MAX == 0);
  assign w_starve_hit        = 1'b0;
`endif

  // State register plus transaction latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_req <= '{owner: OWN_D, we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
          end else if (w_grant_if) begin
            r_req <= '{owner: OWN_IF, we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
          end
        end
        ISSUE: r_cnt <= LAT_C;
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Stores acknowledge with zero data rather than whatever the macro drives.
          if (w_last_wait) begin
            r_rsp_data <= r_req.we ? '0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and registered-state-derived outputs.
  always_comb begin
    w_state_nxt  = r_state;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    d_rsp_valid  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy         = 1'b0;
        if_req_ready = w_grant_if;
        d_req_ready  = w_grant_d;
        if (w_grant_if || w_grant_d) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = r_req.we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_last_wait) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if_rsp_valid = (r_req.owner == OWN_IF);
        d_rsp_valid  = (r_req.owner == OWN_D);
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_addr    = r_req.addr;
  assign mem_wdata   = r_req.wdata;
  assign mem_wstrb   = r_req.wstrb;
  assign if_rsp_data = r_rsp_data;
  assign d_rsp_rdata = r_rsp_data;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: instance A (MEM_LAT=1, STARVE_MAX=2) with a
// byte-writable memory model, instance B (MEM_LAT=3) with a pattern memory.
// Expected responses are queued at accept time and matched when a response pulse appears.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    bit          own_d;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // ---------------- instance A ----------------
  logic        a_rst, a_if_req_valid, a_if_req_ready, a_if_rsp_valid;
  logic [31:0] a_if_addr, a_if_rsp_data;
  logic        a_d_req_valid, a_d_req_ready, a_d_we, a_d_rsp_valid;
  logic [31:0] a_d_addr, a_d_wdata, a_d_rsp_rdata;
  logic [3:0]  a_d_wstrb, a_mem_wstrb;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .if_req_valid(a_if_req_valid), .if_req_ready(a_if_req_ready), .if_addr(a_if_addr),
    .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data),
    .d_req_valid(a_d_req_valid), .d_req_ready(a_d_req_ready), .d_we(a_d_we),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_wstrb(a_d_wstrb),
    .d_rsp_valid(a_d_rsp_valid), .d_rsp_rdata(a_d_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata),
    .busy(a_busy)
  );

  logic [31:0] mem_a [logic [31:0]];
  initial a_mem_rdata = 32'h0;

  always @(posedge clk) begin
    logic [31:0] wv;
    if (a_mem_en) begin
      wv = mem_a.exists(a_mem_addr) ? mem_a[a_mem_addr] : 32'h0;
      if (a_mem_we) begin
        for (int i = 0; i < 4; i++) if (a_mem_wstrb[i]) wv[8*i +: 8] = a_mem_wdata[8*i +: 8];
        mem_a[a_mem_addr] = wv;
      end else begin
        a_mem_rdata <= wv;
      end
    end
  end

  // ---------------- instance B ----------------
  logic        b_rst, b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [31:0] b_if_addr, b_if_rsp_data;
  logic        b_d_req_valid, b_d_req_ready, b_d_we, b_d_rsp_valid;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rsp_rdata;
  logic [3:0]  b_d_wstrb, b_mem_wstrb;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_p1 = 32'h0, b_p2 = 32'h0;

  unified_mem_arbiter #(.MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(b_if_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_we(b_d_we),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_rdata(b_d_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  // Three-stage read pipe: data appears exactly three cycles after mem_en.
  initial b_mem_rdata = 32'h0;
  always @(posedge clk) begin
    b_p1        <= b_mem_en ? (b_mem_addr ^ 32'hCAFE0000) : 32'hBAD0BAD0;
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_if_rsp_valid || a_d_rsp_valid) begin
      chk("a_rsp_onehot", {31'b0, a_if_rsp_valid & a_d_rsp_valid}, 32'h0);
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", {30'b0, a_if_rsp_valid, a_d_rsp_valid}, 32'h0);
      end else begin
        e = qa.pop_front();
        chk("a_rsp_cycle", cyc, e.at);
        chk("a_rsp_owner_d", {31'b0, a_d_rsp_valid}, {31'b0, e.own_d});
        chk("a_rsp_data", e.own_d ? a_d_rsp_rdata : a_if_rsp_data, e.data);
      end
    end
    if (b_if_rsp_valid || b_d_rsp_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", {30'b0, b_if_rsp_valid, b_d_rsp_valid}, 32'h0);
      end else begin
        e = qb.pop_front();
        chk("b_rsp_cycle", cyc, e.at);
        chk("b_rsp_owner_d", {31'b0, b_d_rsp_valid}, {31'b0, e.own_d});
        chk("b_rsp_data", e.own_d ? b_d_rsp_rdata : b_if_rsp_data, e.data);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int w;
    bit exp_d;

    mem_a[32'h10]  = 32'h00500093;
    mem_a[32'h100] = 32'h11112222;
    mem_a[32'h200] = 32'h12345678;

    a_rst = 1'b1; a_if_req_valid = 1'b0; a_if_addr = '0; a_d_req_valid = 1'b0;
    a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0; a_d_wstrb = '0;
    b_rst = 1'b1; b_if_req_valid = 1'b0; b_if_addr = '0; b_d_req_valid = 1'b0;
    b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0; b_d_wstrb = '0;

    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_mem_en", {31'b0, a_mem_en}, 32'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_rsp_data", a_d_rsp_rdata, 32'h0);
    chk("rst_b_busy", {31'b0, b_busy}, 32'h0);

    // 1: lone fetch, then a back-to-back fetch at the earliest legal cycle
    nxt();
    a_if_req_valid = 1'b1; a_if_addr = 32'h10;
    #1; t0 = cyc;
    chk("t1_if_ready", {31'b0, a_if_req_ready}, 32'h1);
    chk("t1_d_ready", {31'b0, a_d_req_ready}, 32'h0);
    qa.push_back('{1'b0, 32'h00500093, t0 + 3});
    nxt(); #1;
    chk("t1_mem_en", {31'b0, a_mem_en}, 32'h1);
    chk("t1_mem_addr", a_mem_addr, 32'h10);
    chk("t1_mem_we", {31'b0, a_mem_we}, 32'h0);
    chk("t1_busy", {31'b0, a_busy}, 32'h1);
    chk("t1_ready_issue", {31'b0, a_if_req_ready}, 32'h0);
    nxt(); #1;
    chk("t1_mem_en_wait", {31'b0, a_mem_en}, 32'h0);
    nxt(); #1;
    chk("t1_ready_resp", {31'b0, a_if_req_ready}, 32'h0);
    nxt(); #1;
    chk("t1_ready_again", {31'b0, a_if_req_ready}, 32'h1);
    qa.push_back('{1'b0, 32'h00500093, cyc + 3});
    nxt();
    a_if_req_valid = 1'b0;
    repeat (3) nxt();

    // 2: collision, data first, fetch accepted when the FSM returns to IDLE
    a_d_req_valid = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    a_if_req_valid = 1'b1; a_if_addr = 32'h10;
    #1; t0 = cyc;
    chk("t2_d_ready", {31'b0, a_d_req_ready}, 32'h1);
    chk("t2_if_ready", {31'b0, a_if_req_ready}, 32'h0);
    qa.push_back('{1'b1, 32'h11112222, t0 + 3});
    nxt();
    a_d_req_valid = 1'b0;
    #1;
    chk("t2_if_wait", {31'b0, a_if_req_ready}, 32'h0);
    nxt(); nxt(); #1;
    chk("t2_if_wait_resp", {31'b0, a_if_req_ready}, 32'h0);
    nxt(); #1;
    chk("t2_if_accept", {31'b0, a_if_req_ready}, 32'h1);
    chk("t2_if_accept_cyc", cyc, t0 + 4);
    qa.push_back('{1'b0, 32'h00500093, t0 + 7});
    nxt();
    a_if_req_valid = 1'b0;
    repeat (3) nxt();

    // 3: partial store, then read-back showing only the enabled bytes changed
    a_d_req_valid = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h200;
    a_d_wdata = 32'hDEADBEEF; a_d_wstrb = 4'b0011;
    #1; t0 = cyc;
    chk("t3_d_ready", {31'b0, a_d_req_ready}, 32'h1);
    qa.push_back('{1'b1, 32'h0, t0 + 3});
    nxt();
    a_d_req_valid = 1'b0; a_d_we = 1'b0;
    #1;
    chk("t3_mem_en", {31'b0, a_mem_en}, 32'h1);
    chk("t3_mem_we", {31'b0, a_mem_we}, 32'h1);
    chk("t3_mem_wstrb", {28'b0, a_mem_wstrb}, 32'h3);
    chk("t3_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    chk("t3_mem_addr", a_mem_addr, 32'h200);
    repeat (3) nxt();
    a_d_req_valid = 1'b1; a_d_addr = 32'h200;
    #1;
    chk("t3_load_ready", {31'b0, a_d_req_ready}, 32'h1);
    qa.push_back('{1'b1, 32'h1234BEEF, cyc + 3});
    nxt();
    a_d_req_valid = 1'b0;
    repeat (3) nxt();

    // 4: MEM_LAT=3 load on instance B
    b_d_req_valid = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h40;
    #1; t0 = cyc;
    chk("t4_d_ready", {31'b0, b_d_req_ready}, 32'h1);
    qb.push_back('{1'b1, 32'hCAFE0040, t0 + 5});
    for (int k = 1; k <= 7; k++) begin
      nxt();
      b_d_req_valid = 1'b0;
      #1;
      chk("t4_busy", {31'b0, b_busy}, (k <= 5) ? 32'h1 : 32'h0);
    end

    // 5: reset in the middle of a load abandons it silently
    a_d_req_valid = 1'b1; a_d_addr = 32'h100;
    #1;
    chk("t5_d_ready", {31'b0, a_d_req_ready}, 32'h1);
    nxt();
    a_d_req_valid = 1'b0;
    nxt();
    a_rst = 1'b1;
    nxt();
    a_rst = 1'b0;
    #1;
    chk("t5_busy", {31'b0, a_busy}, 32'h0);
    chk("t5_mem_en", {31'b0, a_mem_en}, 32'h0);
    chk("t5_mem_we", {31'b0, a_mem_we}, 32'h0);
    chk("t5_mem_addr", a_mem_addr, 32'h0);
    chk("t5_mem_wdata", a_mem_wdata, 32'h0);
    chk("t5_mem_wstrb", {28'b0, a_mem_wstrb}, 32'h0);
    chk("t5_rsp_valids", {30'b0, a_if_rsp_valid, a_d_rsp_valid}, 32'h0);
    chk("t5_rsp_data", a_d_rsp_rdata | a_if_rsp_data, 32'h0);
    chk("t5_readies", {30'b0, a_if_req_ready, a_d_req_ready}, 32'h0);
    repeat (5) nxt();

    // 6: both requesters held valid, six grants
    a_d_req_valid = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    a_if_req_valid = 1'b1; a_if_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      exp_d = GUARD ? ((k % 3) != 2) : 1'b1;
      w = 0;
      #1;
      while (!(a_if_req_ready || a_d_req_ready) && w < 12) begin
        @(posedge clk);
        #2;
        w++;
      end
      chk("t6_grant_seen", {31'b0, a_if_req_ready | a_d_req_ready}, 32'h1);
      chk("t6_grant_is_d", {31'b0, a_d_req_ready}, {31'b0, exp_d});
      qa.push_back('{exp_d, exp_d ? 32'h11112222 : 32'h00500093, cyc + 3});
      nxt();
    end
    a_d_req_valid = 1'b0;
    a_if_req_valid = 1'b0;
    repeat (6) nxt();

    chk("a_all_rsp_seen", qa.size(), 32'h0);
    chk("b_all_rsp_seen", qb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
